// File: rtl/pico_pkg.sv
// Shared types and default widths for the fetch stage.
package pico_pkg;

    localparam int unsigned N_DEFAULT              = 8;
    localparam int unsigned ADDR_SZ_DEFAULT        = 6;
    localparam int unsigned INSTRUCTION_SZ_DEFAULT = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Control, program-memory and decoder-facing signals of the fetch stage.
interface instruction_fetch_if
    import pico_pkg::*;
#(
    parameter int unsigned N             = N_DEFAULT,
    parameter int unsigned AddrSz        = ADDR_SZ_DEFAULT,
    parameter int unsigned InstructionSz = INSTRUCTION_SZ_DEFAULT
) ();

    logic                     start;
    logic                     stall;
    logic                     branch_en;
    logic                     branch_rel;
    logic [N-1:0]             branch_offset;
    logic [AddrSz-1:0]        jump_target;
    logic [AddrSz-1:0]        address;
    logic [InstructionSz-1:0] instruction_in;
    logic [InstructionSz-1:0] instr;
    logic [AddrSz-1:0]        ir_pc;
    logic                     ir_valid;
    logic                     halted;

    // Fetch-stage side.
    modport master (
        input  start, stall, branch_en, branch_rel, branch_offset, jump_target,
        input  instruction_in,
        output address, instr, ir_pc, ir_valid, halted
    );

    // Controller / memory / decoder side.
    modport slave (
        output start, stall, branch_en, branch_rel, branch_offset, jump_target,
        output instruction_in,
        input  address, instr, ir_pc, ir_valid, halted
    );

endinterface

// File: rtl/branch_target_unit.sv
// Combinational branch target: relative (ir_pc + signed offset, wrapped) or absolute.
module branch_target_unit
    import pico_pkg::*;
#(
    parameter int unsigned N      = N_DEFAULT,
    parameter int unsigned AddrSz = ADDR_SZ_DEFAULT
) (
    input  logic [AddrSz-1:0] ir_pc,
    input  logic              branch_rel,
    input  logic [N-1:0]      branch_offset,
    input  logic [AddrSz-1:0] jump_target,
    output logic [AddrSz-1:0] target_c,
    output logic              is_self_c
);

    // Sum is formed wide enough for both operands, then wrapped to the address space.
    localparam int unsigned SumW = (N > AddrSz) ? N : AddrSz;

    logic [AddrSz-1:0] rel_target;

    // Select target and flag the branch-to-self end-of-program idiom.
    always_comb begin
        rel_target = AddrSz'(SumW'(ir_pc) + SumW'($signed(branch_offset)));
        target_c   = branch_rel ? rel_target : jump_target;
        is_self_c  = (target_c == ir_pc);
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: program counter, instruction register and IDLE/RUN/HALT control.
module instruction_fetch
    import pico_pkg::*;
#(
    parameter int unsigned N             = N_DEFAULT,
    parameter int unsigned AddrSz        = ADDR_SZ_DEFAULT,
    parameter int unsigned InstructionSz = INSTRUCTION_SZ_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    instruction_fetch_if.master bus
);

    fetch_state_t             state_q, state_d;
    logic [AddrSz-1:0]        pc_q, pc_d;
    logic [InstructionSz-1:0] instr_q, instr_d;
    logic [AddrSz-1:0]        ir_pc_q, ir_pc_d;
    logic                     ir_valid_q, ir_valid_d;
    logic                     halted_q, halted_d;

    logic [AddrSz-1:0]        target_c;
    logic                     target_is_self_c;
    logic                     take_branch_c;

    branch_target_unit #(
        .N      (N),
        .AddrSz (AddrSz)
    ) u_btu (
        .ir_pc         (ir_pc_q),
        .branch_rel    (bus.branch_rel),
        .branch_offset (bus.branch_offset),
        .jump_target   (bus.jump_target),
        .target_c      (target_c),
        .is_self_c     (target_is_self_c)
    );

    // A branch only counts for a live IR word while running; it beats stall.
    assign take_branch_c = (state_q == RUN) && bus.branch_en && ir_valid_q;

    // State and datapath registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            instr_q    <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= halted_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.start) state_d = RUN;
            RUN:  if (take_branch_c && target_is_self_c) state_d = HALT;
            HALT: if (bus.start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // PC / IR updates per state.
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        halted_d   = halted_q;
        unique case (state_q)
            IDLE: begin
                ir_valid_d = 1'b0;
                if (bus.start) pc_d = '0;
            end
            RUN: begin
                if (take_branch_c) begin
                    ir_valid_d = 1'b0;
                    if (target_is_self_c) halted_d = 1'b1;
                    else                  pc_d     = target_c;
                end else if (!bus.stall) begin
                    instr_d    = bus.instruction_in;
                    ir_pc_d    = pc_q;
                    ir_valid_d = 1'b1;
                    pc_d       = pc_q + AddrSz'(1);
                end
            end
            HALT: begin
                ir_valid_d = 1'b0;
                if (bus.start) begin
                    pc_d     = '0;
                    halted_d = 1'b0;
                end
            end
            default: begin
                ir_valid_d = 1'b0;
                halted_d   = 1'b0;
            end
        endcase
    end

    assign bus.address  = pc_q;
    assign bus.instr    = instr_q;
    assign bus.ir_pc    = ir_pc_q;
    assign bus.ir_valid = ir_valid_q;
    assign bus.halted   = halted_q;

endmodule
